// File: rtl/life_pkg.sv
// Shared types for the Game-of-Life generation sequencer.
// State/command encodings and the cell index helper.
package life_pkg;

  localparam int ROWS_D = 8;
  localparam int COLS_D = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_APPLY1 = 3'd2,
    S_APPLY2 = 3'd3,
    S_RUN    = 3'd4,
    S_STEP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_NONE,
    C_STOP,
    C_LOAD,
    C_RUN,
    C_STEP
  } cmd_t;

  function automatic int cell_idx(
    input int r,
    input int c,
    input int cols
  );
    return r * cols + c;
  endfunction

endpackage

// File: rtl/life_period_timer.sv
// Generation period timer for free-run mode.
// Latches max(period,1) on start and ticks on the last count.
module life_period_timer #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic [PERIOD_W-1:0] i_period,
  output logic                o_tick
);

  logic [PERIOD_W-1:0] r_p;
  logic [PERIOD_W-1:0] r_cnt;
  logic                r_active;

  assign o_tick = r_active &&
                  (r_cnt == r_p - PERIOD_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_p      <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (i_stop) begin
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (i_start) begin
      r_p      <= (i_period == '0) ?
                  PERIOD_W'(1) : i_period;
      r_cnt    <= '0;
      r_active <= 1'b1;
    end else if (r_active) begin
      r_cnt <= o_tick ? '0 : r_cnt + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/life_gen_ctrl.sv
// Generation sequencer: seed load, grid apply, run/step.
// Owns the grid-wide cell reset, enable and init nets.
module life_gen_ctrl
  import life_pkg::*;
#(
  parameter int ROWS     = ROWS_D,
  parameter int COLS     = COLS_D,
  parameter int PERIOD_W = 24,
  parameter int GEN_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_load,
  input  logic                 cmd_run,
  input  logic                 cmd_stop,
  input  logic                 cmd_step,
  input  logic [PERIOD_W-1:0]  period,
  input  logic                 seed_valid,
  output logic                 seed_ready,
  input  logic [COLS-1:0]      seed_row,
  output logic [ROWS*COLS-1:0] cell_init,
  output logic                 cell_rst,
  output logic                 cell_en,
  output logic [GEN_W-1:0]     gen_count,
  output logic                 running,
  output logic                 seeded,
  output logic                 cmd_err
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  state_t               r_state;
  logic [RW-1:0]        r_row;
  logic [ROWS*COLS-1:0] r_cell_init;
  logic                 r_seed_ready;
  logic                 r_cell_rst;
  logic                 r_cell_en;
  logic [GEN_W-1:0]     r_gen;
  logic                 r_running;
  logic                 r_seeded;
  logic                 r_cmd_err;

  cmd_t w_cmd;
  logic w_tick;
  logic w_start;
  logic w_stop;
  logic w_xfer;
  logic w_last;

  // Highest-priority command wins; the rest are dropped silently.
  always_comb begin
    w_cmd = C_NONE;
    priority case (1'b1)
      cmd_stop: w_cmd = C_STOP;
      cmd_load: w_cmd = C_LOAD;
      cmd_run:  w_cmd = C_RUN;
      cmd_step: w_cmd = C_STEP;
      default:  w_cmd = C_NONE;
    endcase
  end

  assign w_start = (r_state == S_IDLE) &&
                   (w_cmd == C_RUN) && r_seeded;
  assign w_stop  = (r_state == S_RUN) &&
                   ((w_cmd == C_STOP) ||
                    (w_cmd == C_LOAD));
  assign w_xfer  = seed_valid && r_seed_ready;
  assign w_last  = (r_row == RW'(ROWS - 1));

  life_period_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_start),
    .i_stop   (w_stop),
    .i_period (period),
    .o_tick   (w_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_row        <= '0;
      r_cell_init  <= '0;
      r_seed_ready <= 1'b0;
      r_cell_rst   <= 1'b0;
      r_cell_en    <= 1'b0;
      r_gen        <= '0;
      r_running    <= 1'b0;
      r_seeded     <= 1'b0;
      r_cmd_err    <= 1'b0;
    end else begin
      r_cmd_err  <= 1'b0;
      r_cell_en  <= 1'b0;
      r_cell_rst <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          case (w_cmd)
            C_LOAD: begin
              r_state      <= S_LOAD;
              r_row        <= '0;
              r_seeded     <= 1'b0;
              r_seed_ready <= 1'b1;
            end
            C_RUN: begin
              if (r_seeded) begin
                r_state   <= S_RUN;
                r_running <= 1'b1;
              end else begin
                r_cmd_err <= 1'b1;
              end
            end
            C_STEP: begin
              if (r_seeded) r_state <= S_STEP;
              else          r_cmd_err <= 1'b1;
            end
            default: ;
          endcase
        end
        S_LOAD: begin
          case (w_cmd)
            C_STOP: begin
              r_state      <= S_IDLE;
              r_seed_ready <= 1'b0;
            end
            C_LOAD: r_row <= '0;
            default: begin
              r_cmd_err <= (w_cmd != C_NONE);
              if (w_xfer) begin
                r_cell_init[cell_idx(int'(r_row), 0, COLS)
                            +: COLS] <= seed_row;
                r_row <= w_last ? '0 : r_row + RW'(1);
                if (w_last) begin
                  r_state      <= S_APPLY1;
                  r_seed_ready <= 1'b0;
                  r_cell_rst   <= 1'b1;
                end
              end
            end
          endcase
        end
        // Apply is atomic: every command here is refused.
        S_APPLY1: begin
          r_cmd_err <= (w_cmd != C_NONE);
          r_gen     <= '0;
          r_cell_en <= 1'b1;
          r_state   <= S_APPLY2;
        end
        S_APPLY2: begin
          r_cmd_err <= (w_cmd != C_NONE);
          r_seeded  <= 1'b1;
          r_state   <= S_IDLE;
        end
        S_RUN: begin
          case (w_cmd)
            C_STOP: begin
              r_state   <= S_IDLE;
              r_running <= 1'b0;
            end
            C_LOAD: begin
              r_state      <= S_LOAD;
              r_running    <= 1'b0;
              r_row        <= '0;
              r_seeded     <= 1'b0;
              r_seed_ready <= 1'b1;
            end
            default: begin
              r_cmd_err <= (w_cmd != C_NONE);
              if (w_tick) begin
                r_cell_en <= 1'b1;
                r_gen     <= r_gen + GEN_W'(1);
              end
            end
          endcase
        end
        S_STEP: begin
          r_cmd_err <= (w_cmd != C_NONE) &&
                       (w_cmd != C_STOP);
          r_cell_en <= 1'b1;
          r_gen     <= r_gen + GEN_W'(1);
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign seed_ready = r_seed_ready;
  assign cell_init  = r_cell_init;
  assign cell_rst   = r_cell_rst;
  assign cell_en    = r_cell_en;
  assign gen_count  = r_gen;
  assign running    = r_running;
  assign seeded     = r_seeded;
  assign cmd_err    = r_cmd_err;

endmodule

// File: tb/tb_life_gen_ctrl.sv
// Directed bench for life_gen_ctrl (GEN_W=4 to reach wrap).
// Expected values queued with stimulus, popped at observation.
module tb_life_gen_ctrl;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int PW   = 24;
  localparam int GW   = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 cmd_load, cmd_run;
  logic                 cmd_stop, cmd_step;
  logic [PW-1:0]        period;
  logic                 seed_valid;
  logic                 seed_ready;
  logic [COLS-1:0]      seed_row;
  logic [ROWS*COLS-1:0] cell_init;
  logic                 cell_rst, cell_en;
  logic [GW-1:0]        gen_count;
  logic                 running, seeded, cmd_err;

  typedef struct {
    string       tag;
    logic [63:0] v;
  } exp_t;

  exp_t q[$];
  int   errs = 0;
  int   nchk = 0;
  int   en_cnt = 0;
  int   ovl = 0;
  int   n0;
  logic [63:0] pat;

  always #5 clk = ~clk;

  life_gen_ctrl #(
    .ROWS(ROWS), .COLS(COLS),
    .PERIOD_W(PW), .GEN_W(GW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_load(cmd_load), .cmd_run(cmd_run),
    .cmd_stop(cmd_stop), .cmd_step(cmd_step),
    .period(period),
    .seed_valid(seed_valid), .seed_ready(seed_ready),
    .seed_row(seed_row), .cell_init(cell_init),
    .cell_rst(cell_rst), .cell_en(cell_en),
    .gen_count(gen_count), .running(running),
    .seeded(seeded), .cmd_err(cmd_err)
  );

  always @(negedge clk) begin
    if (cell_en) en_cnt++;
    if (cell_en && cell_rst) ovl++;
  end

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string t, input logic [63:0] v);
    exp_t e;
    e.tag = t;
    e.v   = v;
    q.push_back(e);
  endtask

  task automatic chk(input logic [63:0] obs);
    exp_t e;
    nchk++;
    if (q.size() == 0) begin
      errs++;
      $error("FAIL sb_empty: observed %0h with no expectation", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.v) else begin
        errs++;
        $error("FAIL %s: observed %0h expected %0h",
               e.tag, obs, e.v);
      end
    end
  endtask

  task automatic all_zero(input string t);
    push({t, "_en"}, 64'd0);     chk(64'(cell_en));
    push({t, "_rst"}, 64'd0);    chk(64'(cell_rst));
    push({t, "_run"}, 64'd0);    chk(64'(running));
    push({t, "_seeded"}, 64'd0); chk(64'(seeded));
    push({t, "_ready"}, 64'd0);  chk(64'(seed_ready));
    push({t, "_err"}, 64'd0);    chk(64'(cmd_err));
    push({t, "_gen"}, 64'd0);    chk(64'(gen_count));
    push({t, "_init"}, 64'd0);   chk(64'(cell_init));
  endtask

  // Leaves the bench in the APPLY1 cycle.
  task automatic load_seed(input logic [63:0] p);
    cmd_load = 1'b1;
    clk1();
    cmd_load = 1'b0;
    push("load_ready", 64'd1);
    chk(64'(seed_ready));
    for (int r = 0; r < ROWS; r++) begin
      if (r % 2 == 1) begin
        seed_valid = 1'b0;
        clk1();
      end
      seed_valid = 1'b1;
      seed_row   = p[r*COLS +: COLS];
      clk1();
    end
    seed_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_load = 1'b0; cmd_run = 1'b0;
    cmd_stop = 1'b0; cmd_step = 1'b0;
    period = '0; seed_valid = 1'b0; seed_row = '0;
    clk1(); clk1();
    all_zero("reset");
    rst_n = 1'b1;
    clk1();

    // Unseeded run/step are refused.
    cmd_run = 1'b1;
    push("err_run_unseeded", 64'd1);
    push("run_stays_idle", 64'd0);
    clk1();
    cmd_run = 1'b0;
    chk(64'(cmd_err));
    chk(64'(running));
    push("err_one_cycle", 64'd0);
    clk1();
    chk(64'(cmd_err));
    cmd_step = 1'b1;
    push("err_step_unseeded", 64'd1);
    clk1();
    cmd_step = 1'b0;
    chk(64'(cmd_err));
    clk1(); clk1();
    push("no_en_unseeded", 64'd0);
    chk(64'(en_cnt));

    // Diagonal seed.
    load_seed(64'h8040201008040201);
    push("diag_init", 64'h8040201008040201);
    chk(64'(cell_init));
    push("apply1_rst", 64'd1);   chk(64'(cell_rst));
    push("apply1_ready", 64'd0); chk(64'(seed_ready));
    push("apply1_en", 64'd0);    chk(64'(cell_en));
    clk1();
    push("apply2_rst", 64'd0);   chk(64'(cell_rst));
    push("apply2_en", 64'd1);    chk(64'(cell_en));
    push("apply2_gen", 64'd0);   chk(64'(gen_count));
    clk1();
    push("apply_done_en", 64'd0);  chk(64'(cell_en));
    push("apply_seeded", 64'd1);   chk(64'(seeded));

    // RUN with period 5: pulses at k+6, k+11, k+16.
    period = 24'd5;
    cmd_run = 1'b1;
    clk1();
    cmd_run = 1'b0;
    period = 24'd2;
    push("run_entry", 64'd1);
    chk(64'(running));
    for (int j = 1; j <= 16; j++) begin
      push($sformatf("p5_en_k+%0d", j),
           64'((j == 6) || (j == 11) || (j == 16)));
      push($sformatf("p5_gen_k+%0d", j),
           64'(int'(j >= 6) + int'(j >= 11) + int'(j >= 16)));
      chk(64'(cell_en));
      chk(64'(gen_count));
      if (j < 16) clk1();
    end
    cmd_stop = 1'b1;
    clk1();
    cmd_stop = 1'b0;
    push("p5_stop_run", 64'd0); chk(64'(running));
    push("p5_stop_gen", 64'd3); chk(64'(gen_count));

    // Period 0 behaves as 1; stop on a tick edge suppresses it.
    period = 24'd0;
    cmd_run = 1'b1;
    clk1();
    cmd_run = 1'b0;
    period = 24'd9;
    push("p0_entry_en", 64'd0); chk(64'(cell_en));
    clk1();
    push("p0_en1", 64'd1);  chk(64'(cell_en));
    push("p0_gen1", 64'd4); chk(64'(gen_count));
    clk1();
    push("p0_en2", 64'd1);  chk(64'(cell_en));
    push("p0_gen2", 64'd5); chk(64'(gen_count));
    cmd_stop = 1'b1;
    clk1();
    cmd_stop = 1'b0;
    push("p0_stop_en", 64'd0);  chk(64'(cell_en));
    push("p0_stop_gen", 64'd5); chk(64'(gen_count));
    push("p0_stop_run", 64'd0); chk(64'(running));

    // Stop+load+step together: stop wins, no error.
    period = 24'd0;
    cmd_run = 1'b1;
    clk1();
    cmd_run = 1'b0;
    cmd_stop = 1'b1; cmd_load = 1'b1; cmd_step = 1'b1;
    clk1();
    cmd_stop = 1'b0; cmd_load = 1'b0; cmd_step = 1'b0;
    push("prio_err", 64'd0);   chk(64'(cmd_err));
    push("prio_run", 64'd0);   chk(64'(running));
    push("prio_ready", 64'd0); chk(64'(seed_ready));
    push("prio_en", 64'd0);    chk(64'(cell_en));
    n0 = en_cnt;
    cmd_step = 1'b1;
    clk1();
    cmd_step = 1'b0;
    push("step_lat1_en", 64'd0); chk(64'(cell_en));
    clk1();
    push("step_lat2_en", 64'd1); chk(64'(cell_en));
    push("step_gen", 64'd6);     chk(64'(gen_count));
    clk1();
    push("step_en_off", 64'd0);  chk(64'(cell_en));
    clk1();
    push("step_one_pulse", 64'(n0 + 1));
    chk(64'(en_cnt));

    // Reload; apply ignores stop and clears gen_count.
    pat = 64'hA55A0FF03CC38001;
    load_seed(pat);
    push("reload_init", 64'hA55A0FF03CC38001);
    chk(64'(cell_init));
    push("reload_rst", 64'd1); chk(64'(cell_rst));
    cmd_stop = 1'b1;
    clk1();
    cmd_stop = 1'b0;
    push("apply_stop_err", 64'd1); chk(64'(cmd_err));
    push("apply_stop_en", 64'd1);  chk(64'(cell_en));
    push("apply_gen_clr", 64'd0);  chk(64'(gen_count));
    clk1();
    push("reload_seeded", 64'd1);  chk(64'(seeded));

    // 17 steps with a 4-bit counter: 15 -> 0 -> 1.
    for (int i = 1; i <= 17; i++) begin
      cmd_step = 1'b1;
      clk1();
      cmd_step = 1'b0;
      clk1();
      push($sformatf("wrap_gen_%0d", i), 64'(i % 16));
      chk(64'(gen_count));
      clk1();
    end

    // Reset mid-load at row 3.
    cmd_load = 1'b1;
    clk1();
    cmd_load = 1'b0;
    for (int r = 0; r < 3; r++) begin
      seed_valid = 1'b1;
      seed_row   = 8'hFF;
      clk1();
    end
    seed_row = 8'h11;
    rst_n = 1'b0;
    clk1();
    all_zero("midload_rst");
    rst_n = 1'b1;
    seed_valid = 1'b0;
    clk1();

    push("no_rst_en_overlap", 64'd0);
    chk(64'(ovl));
    push("sb_drained", 64'd0);
    chk(64'(q.size() - 1));

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
